// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel-clock divider, h/v counters, registered sync/blank/strobes.
// Define VGA_TESTPAT_EN to add a 3-bit rgb colour-bar test pattern output.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC_W = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC_W = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int CLK_DIV  = 2,
  parameter int CNT_W    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             h_sync,
  output logic             v_sync,
  output logic             video_on,
  output logic             pix_tick,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_TESTPAT_EN
  ,
  output logic [2:0]       rgb
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC_W + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC_W + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC_W - 1);
  localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC_W - 1);
  localparam logic             H_ON     = (H_POL != 0);
  localparam logic             V_ON     = (V_POL != 0);

  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic             tick, h_wrap, v_wrap;
  logic             hs_d, vs_d, vid_d;

  // Strobes raised at the counter update; delayed one stage to line up with x/y.
  logic [2:0]       stb_q;  // {frame, line, pix}

  logic [CNT_W-1:0] x_q, y_q;
  logic             hs_q, vs_q, vid_q, pt_q, ls_q, fs_q;

  always_comb begin
    tick    = en && (div_q == DIV_LAST);
    h_wrap  = (h_cnt_q == H_LAST);
    v_wrap  = (v_cnt_q == V_LAST);
    div_d   = div_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (en) div_d = tick ? '0 : div_q + 1'b1;
    if (tick) begin
      h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
      if (h_wrap) v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
    end
    hs_d  = (h_cnt_q >= HS_BEG && h_cnt_q <= HS_END) ? H_ON : ~H_ON;
    vs_d  = (v_cnt_q >= VS_BEG && v_cnt_q <= VS_END) ? V_ON : ~V_ON;
    vid_d = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= '0;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      stb_q   <= '0;
    end else begin
      div_q   <= div_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      // Held while frozen so a pending pixel strobe is delivered on resume.
      if (en) stb_q <= {tick && h_wrap && v_wrap, tick && h_wrap, tick};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q   <= '0;
      y_q   <= '0;
      hs_q  <= ~H_ON;
      vs_q  <= ~V_ON;
      vid_q <= 1'b0;
      pt_q  <= 1'b0;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else if (en) begin
      x_q   <= h_cnt_q;
      y_q   <= v_cnt_q;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      vid_q <= vid_d;
      pt_q  <= stb_q[0];
      ls_q  <= stb_q[1];
      fs_q  <= stb_q[2];
    end else begin
      pt_q  <= 1'b0;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign h_sync      = hs_q;
  assign v_sync      = vs_q;
  assign video_on    = vid_q;
  assign pix_tick    = pt_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

`ifdef VGA_TESTPAT_EN
  localparam logic [CNT_W-1:0] BAR_W = CNT_W'((H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1);

  logic [CNT_W-1:0] bar;
  logic [2:0]       rgb_d, rgb_q;

  // Bars run white (7) down to black (0); any remainder column past bar 7 is blank.
  always_comb begin
    bar   = h_cnt_q / BAR_W;
    rgb_d = (vid_d && bar < CNT_W'(8)) ? 3'd7 - bar[2:0] : 3'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rgb_q <= 3'd0;
    else if (en) rgb_q <= rgb_d;
  end

  assign rgb = rgb_q;
`endif

endmodule
